// File: rtl/ym3438_host_pkg.sv
// Shared types and bus encodings for the YM3438 host write sequencer.
package ym3438_host_pkg;

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_STROBE, A_HOLD, GAP1, D_SETUP, D_STROBE, D_HOLD,
    GAP2, R_SETUP, R_STROBE, R_GAP, WAIT
  } state_t;

  localparam int         TMR_W       = 10;
  localparam int         BANK_BIT    = 1;
  localparam int         BUSY_BIT    = 7;
  localparam logic [1:0] ADDR_STATUS = 2'b00;
  localparam logic       ADDR_A0     = 1'b0;
  localparam logic       ADDR_D0     = 1'b1;

  function automatic logic [1:0] addr_enc(input logic bank, input logic sel);
    logic [1:0] a;
    a           = '0;
    a[BANK_BIT] = bank;
    a[0]        = sel;
    return a;
  endfunction

endpackage

// File: rtl/ym3438_host_strobe_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module ym3438_host_strobe_timer
  import ym3438_host_pkg::*;
(
  input  logic             mclk_i,
  input  logic             ic_n_i,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             tc_o
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge mclk_i or negedge ic_n_i) begin
    if (!ic_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/ym3438_host_if.sv
// YM3438 host write sequencer: address write, data write, then busy wait.
// Macro YM3438_HOST_BUSY_POLL_EN selects status polling instead of a fixed wait.
//   state    | meaning
//   IDLE     | ready for a request
//   A_*      | address write: setup, WR strobe, hold
//   GAP1     | CS high between address and data writes
//   D_*      | data write: setup, WR strobe, hold
//   GAP2     | CS high after the data write
//   R_*      | status read: setup, RD strobe, CS-high gap
//   WAIT     | fixed busy delay with CS high
module ym3438_host_if
  import ym3438_host_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int BUSY_CYCLES   = 192,
  parameter int POLL_LIMIT    = 255
) (
  input  logic       MCLK,
  input  logic       IC,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_bank,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic [1:0] ADDRESS,
  output logic [7:0] DATA_o,
  output logic       DATA_oe,
  input  logic [7:0] DATA_i,
  output logic       done,
  output logic       timeout
);

  localparam logic [TMR_W-1:0] SETUP_LD  = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] STROBE_LD = TMR_W'(STROBE_CYCLES - 1);
  localparam logic [TMR_W-1:0] BUSY_LD   = TMR_W'(BUSY_CYCLES - 1);
  localparam logic [7:0]       POLL_LIM8 = 8'(POLL_LIMIT);

  state_t           state_q;
  logic             cs_q, wr_q, rd_q, oe_q, done_q, timeout_q, bank_q, busy_q;
  logic [1:0]       addr_q;
  logic [7:0]       dout_q, data_q, poll_cnt_q;
  logic             tmr_load_d, tmr_tc;
  logic [TMR_W-1:0] tmr_val_d;
  logic             unused_status;

  // Only the busy flag of the status byte steers the sequencer.
  assign unused_status = ^DATA_i[6:0];

  always_comb begin
    tmr_load_d = 1'b0;
    tmr_val_d  = '0;
    case (state_q)
      IDLE:     if (req_valid) begin tmr_load_d = 1'b1; tmr_val_d = SETUP_LD; end
      GAP1:     begin tmr_load_d = 1'b1; tmr_val_d = SETUP_LD; end
      A_SETUP, D_SETUP, R_SETUP:
                if (tmr_tc) begin tmr_load_d = 1'b1; tmr_val_d = STROBE_LD; end
`ifdef YM3438_HOST_BUSY_POLL_EN
      GAP2:     begin tmr_load_d = 1'b1; tmr_val_d = SETUP_LD; end
`else
      GAP2:     begin tmr_load_d = 1'b1; tmr_val_d = BUSY_LD; end
`endif
      R_GAP:    if (busy_q && (poll_cnt_q < POLL_LIM8)) begin
                  tmr_load_d = 1'b1; tmr_val_d = SETUP_LD;
                end
      default:  ;
    endcase
  end

  ym3438_host_strobe_timer u_timer (
    .mclk_i     (MCLK),
    .ic_n_i     (IC),
    .load_i     (tmr_load_d),
    .load_val_i (tmr_val_d),
    .tc_o       (tmr_tc)
  );

  always_ff @(posedge MCLK or negedge IC) begin
    if (!IC) begin
      state_q    <= IDLE;
      cs_q       <= 1'b1;
      wr_q       <= 1'b1;
      rd_q       <= 1'b1;
      oe_q       <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      data_q     <= '0;
      bank_q     <= 1'b0;
      busy_q     <= 1'b0;
      poll_cnt_q <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (req_valid) begin
          state_q    <= A_SETUP;
          bank_q     <= req_bank;
          data_q     <= req_data;
          addr_q     <= addr_enc(req_bank, ADDR_A0);
          dout_q     <= req_addr;
          cs_q       <= 1'b0;
          oe_q       <= 1'b1;
          poll_cnt_q <= '0;
          timeout_q  <= 1'b0;
        end
        A_SETUP:  if (tmr_tc) begin state_q <= A_STROBE; wr_q <= 1'b0; end
        A_STROBE: if (tmr_tc) begin state_q <= A_HOLD;   wr_q <= 1'b1; end
        A_HOLD:   begin state_q <= GAP1; cs_q <= 1'b1; end
        GAP1: begin
          state_q <= D_SETUP;
          cs_q    <= 1'b0;
          addr_q  <= addr_enc(bank_q, ADDR_D0);
          dout_q  <= data_q;
        end
        D_SETUP:  if (tmr_tc) begin state_q <= D_STROBE; wr_q <= 1'b0; end
        D_STROBE: if (tmr_tc) begin state_q <= D_HOLD;   wr_q <= 1'b1; end
        D_HOLD: begin
          state_q <= GAP2;
          cs_q    <= 1'b1;
          oe_q    <= 1'b0;
          addr_q  <= ADDR_STATUS;
        end
`ifdef YM3438_HOST_BUSY_POLL_EN
        GAP2:     begin state_q <= R_SETUP; cs_q <= 1'b0; end
`else
        GAP2:     state_q <= WAIT;
`endif
        R_SETUP:  if (tmr_tc) begin state_q <= R_STROBE; rd_q <= 1'b0; end
        R_STROBE: if (tmr_tc) begin
          state_q    <= R_GAP;
          rd_q       <= 1'b1;
          cs_q       <= 1'b1;
          busy_q     <= DATA_i[BUSY_BIT];
          poll_cnt_q <= poll_cnt_q + 8'd1;
        end
        R_GAP: begin
          if (!busy_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (poll_cnt_q < POLL_LIM8) begin
            state_q <= R_SETUP;
            cs_q    <= 1'b0;
          end else begin
            state_q   <= IDLE;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        WAIT:     if (tmr_tc) begin state_q <= IDLE; done_q <= 1'b1; end
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign CS        = cs_q;
  assign WR        = wr_q;
  assign RD        = rd_q;
  assign ADDRESS   = addr_q;
  assign DATA_o    = dout_q;
  assign DATA_oe   = oe_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/ym3438_host_if.md
YM3438_HOST_IF -- requirements
Module: ym3438_host_if

Interface
REQ-001 Parameter SETUP_CYCLES, default 2: MCLK cycles with CS low and address/data stable before each WR or RD strobe (range 1..15).
REQ-002 Parameter STROBE_CYCLES, default 4: MCLK cycles WR or RD is held low per access (range 1..15).
REQ-003 Parameter BUSY_CYCLES, default 192: fixed post-data-write wait, used when busy polling is compiled out (range 1..1023).
REQ-004 Parameter POLL_LIMIT, default 255: maximum status reads per write before timeout (range 1..255).
REQ-005 MCLK  in  1  sole clock, all state changes on rising edge.
REQ-006 IC  in  1  reset, asynchronous, active-low.
REQ-007 req_valid  in  1  host write request; req_ready  out  1  high only in IDLE.
REQ-008 req_bank  in  1, req_addr  in  8, req_data  in  8  register bank, register number, value; captured on valid&&ready.
REQ-009 CS, WR, RD  out  1 each, active-low chip strobes; ADDRESS  out  2; DATA_o  out  8; DATA_oe  out  1 (1 = this block drives the data bus).
REQ-010 DATA_i  in  8  chip data bus read back during RD.
REQ-011 done  out  1  one-cycle pulse when a write transaction fully completes; timeout  out  1  sticky, cleared by the next accepted request.

Function
REQ-012 One transaction = address phase (ADDRESS={req_bank,0}, DATA_o=req_addr), then data phase (ADDRESS={req_bank,1}, DATA_o=req_data), then busy phase.
REQ-013 States: IDLE, A_SETUP, A_STROBE, A_HOLD, GAP1, D_SETUP, D_STROBE, D_HOLD, GAP2, R_SETUP, R_STROBE, R_GAP, WAIT.
REQ-014 IDLE -> A_SETUP on valid&&ready; no other state accepts requests.
REQ-015 *_SETUP: CS=0, WR=1, RD=1 for SETUP_CYCLES; *_STROBE: CS=0, WR=0 for STROBE_CYCLES; *_HOLD: CS=0, WR=1 for exactly 1 cycle; GAP1/GAP2: CS=1 for exactly 1 cycle.
REQ-016 DATA_oe=1 from A_SETUP through D_HOLD inclusive; 0 in every other state, so WR and RD are never low together and DATA_oe is never 1 while RD=0.
REQ-017 ADDRESS and DATA_o change only in states where CS=1 or on entry to A_SETUP/D_SETUP; they are stable through each strobe and hold cycle.
REQ-018 Busy phase (polling): R_SETUP drives ADDRESS=0, CS=0, RD=1; R_STROBE drives RD=0 for STROBE_CYCLES; DATA_i is sampled on the last R_STROBE cycle; R_GAP is 1 cycle with CS=1.
REQ-019 After R_GAP: sampled bit7=0 -> done pulse and IDLE; bit7=1 with poll count < POLL_LIMIT -> R_SETUP; bit7=1 with count = POLL_LIMIT -> timeout=1, done pulse, IDLE.
REQ-020 The poll counter is 8 bits, cleared on A_SETUP entry, and incremented once per completed read.
REQ-021 done asserts in the cycle IDLE is re-entered; req_ready is high in that same cycle, so back-to-back requests lose no cycles.

Reset
REQ-022 IC low: state=IDLE, CS=WR=RD=1, DATA_oe=0, ADDRESS=0, DATA_o=0, done=0, timeout=0, counters=0, all immediately and asynchronously, including mid-strobe.
REQ-023 After IC deasserts, the first request may be accepted on the first rising edge at which IC is high.

Configuration
REQ-024 With macro YM3438_HOST_BUSY_POLL_EN defined, the busy phase is R_SETUP/R_STROBE/R_GAP polling per REQ-018..020.
REQ-025 Without the macro, GAP2 goes to WAIT, which holds CS=1 for BUSY_CYCLES cycles, then pulses done and returns to IDLE. RD stays 1 permanently, DATA_i is ignored, and timeout stays 0.

Structure
REQ-026 The shared package ym3438_host_pkg holds the state enum, the ADDRESS encodings (ADDR_STATUS=0, ADDR_A0=0, ADDR_D0=1, bank bit position) and the BUSY_BIT=7 constant.
REQ-027 One sub-module, ym3438_host_strobe_timer: a loadable down-counter that produces a terminal-count flag and is shared by the setup, strobe and wait intervals.

Verification
REQ-028 Defaults, polling on: write bank0 reg 0x28 data 0xF0; status reads 0x80, 0x80, 0x00 -> WR low 4 cycles twice, exactly 3 RD strobes, done after the third, bus shows 0x28 then 0xF0.
REQ-029 Bank1 reg 0xA4 data 0x22 -> ADDRESS=2 during the address strobe and ADDRESS=3 during the data strobe.
REQ-030 Polling on, POLL_LIMIT=3, status stuck at 0xFF -> 3 reads, timeout=1, done pulse; the next request clears timeout.
REQ-031 Polling off, BUSY_CYCLES=10 -> RD never low; done exactly 10 cycles after GAP2; total latency = 2*(2+4+1)+2+10 cycles from accept to done.
REQ-032 IC pulled low during D_STROBE -> WR, CS, DATA_oe release in the same cycle; state is IDLE; no done pulse.
REQ-033 Two requests back-to-back with req_valid held high -> the second is accepted in the done cycle; the assertion "WR and RD never both low" holds throughout.
